// File: rtl/scmp_uart_pkg.sv
// ============================================================================
// Module : scmp_uart_pkg
// Brief  : Shared constants, FSM state types and divisor helpers for scmp_uart.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scmp_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  localparam int STAT_RX_AVAIL   = 0;
  localparam int STAT_TX_READY   = 1;
  localparam int STAT_RX_OVERRUN = 2;
  localparam int STAT_FRAME_ERR  = 3;

  localparam logic [15:0] DIV_RESET_DEFAULT = 16'd3333;
  localparam int          RX_FIFO_DEPTH     = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  // Counter reload for one bit period; a zero divisor behaves as one.
  function automatic logic [15:0] bit_reload(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

  function automatic logic [15:0] half_reload(input logic [15:0] div);
    logic [15:0] half;
    half = div >> 1;
    return (half == 16'd0) ? 16'd0 : half - 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scmp_uart_if.sv
// ============================================================================
// Module : scmp_uart_if
// Brief  : SC/MP-style CPU register bus between the CPU and the UART.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface scmp_uart_if;
  logic [15:0] addr;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        sel;

  modport master (output addr, rd_n, wr_n, wdata, input rdata, sel);
  modport slave  (input addr, rd_n, wr_n, wdata, output rdata, sel);
endinterface

`default_nettype wire

// File: rtl/scmp_uart_fifo.sv
// ============================================================================
// Module : scmp_uart_fifo
// Brief  : Byte FIFO for received data; push and pop may coincide when full.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scmp_uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/scmp_uart.sv
// ============================================================================
// Module : scmp_uart
// Brief  : Memory-mapped 8N1 UART for an SC/MP bus. Define SCMP_UART_RXFIFO_EN
//          for an 8-entry RX FIFO; otherwise a single RX holding register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scmp_uart
  import scmp_uart_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'hFD00,
  parameter logic [15:0] DIV_RESET = DIV_RESET_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  scmp_uart_if.slave       bus,
  input  logic             rxd,
  output logic             txd,
  output logic             irq
);

  logic [1:0]  off;
  logic        wr_n_q, rd_sel_q;
  logic [1:0]  rd_off_q;
  logic        write_evt, rd_rise, pop, stat_clr, tx_load, div_wr;
  logic [7:0]  div_lo_q, div_lo_d, div_hi_q, div_hi_d;
  logic [15:0] bit_rl, half_rl;

  assign off       = bus.addr[1:0];
  assign bus.sel   = (bus.addr[15:2] == BASE[15:2]);
  assign write_evt = bus.sel && !bus.wr_n && wr_n_q;
  assign rd_rise   = rd_sel_q && bus.rd_n;
  assign pop       = rd_rise && (rd_off_q == REG_DATA);
  assign stat_clr  = rd_rise && (rd_off_q == REG_STATUS);
  assign tx_load   = write_evt && (off == REG_DATA);
  assign div_wr    = write_evt && ((off == REG_DIV_LO) || (off == REG_DIV_HI));

  always_comb begin
    div_lo_d = div_lo_q;
    div_hi_d = div_hi_q;
    if (write_evt && off == REG_DIV_LO) div_lo_d = bus.wdata;
    if (write_evt && off == REG_DIV_HI) div_hi_d = bus.wdata;
  end

  // Reloads use the post-write divisor so a divisor write restarts at the new rate.
  assign bit_rl  = bit_reload({div_hi_d, div_lo_d});
  assign half_rl = half_reload({div_hi_d, div_lo_d});

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_n_q   <= 1'b1;
      rd_sel_q <= 1'b0;
      rd_off_q <= 2'd0;
      div_lo_q <= DIV_RESET[7:0];
      div_hi_q <= DIV_RESET[15:8];
    end else begin
      wr_n_q   <= bus.wr_n;
      rd_sel_q <= bus.sel && !bus.rd_n;
      if (bus.sel && !bus.rd_n) rd_off_q <= off;
      div_lo_q <= div_lo_d;
      div_hi_q <= div_hi_d;
    end
  end

  tx_state_t   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic        txd_q, txd_d, tx_tick, tx_ready;

  assign tx_tick  = (tx_cnt_q == 16'd0);
  assign tx_ready = (tx_state_q == TX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= 16'd0;
      tx_shift_q <= 8'h00;
      tx_bit_q   <= 3'd0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? bit_rl : tx_cnt_q - 16'd1;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (tx_load) begin
          tx_state_d = TX_START;
          tx_shift_d = bus.wdata;
          tx_cnt_d   = bit_rl;
          txd_d      = 1'b0;
        end
      end
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = 3'd0;
        txd_d      = tx_shift_q[0];
      end
      TX_DATA: if (tx_tick) begin
        if (tx_bit_q == 3'd7) begin
          tx_state_d = TX_STOP;
          txd_d      = 1'b1;
        end else begin
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          txd_d      = tx_shift_q[1];
        end
      end
      TX_STOP: if (tx_tick) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    if (div_wr) tx_cnt_d = bit_rl;
  end

  rx_state_t   rx_state_q, rx_state_d;
  logic [2:0]  rx_sync_q;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_in, rx_fall, rx_tick, rx_push, ferr_set;

  assign rx_in   = rx_sync_q[1];
  assign rx_fall = rx_sync_q[2] && !rx_sync_q[1];
  assign rx_tick = (rx_cnt_q == 16'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_q  <= 3'b111;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= 16'd0;
      rx_shift_q <= 8'h00;
      rx_bit_q   <= 3'd0;
    end else begin
      rx_sync_q  <= {rx_sync_q[1:0], rxd};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_tick ? bit_rl : rx_cnt_q - 16'd1;
    rx_shift_d = rx_shift_q;
    rx_bit_d   = rx_bit_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_fall) begin
        rx_state_d = RX_START;
        rx_cnt_d   = half_rl;
      end
      RX_START: if (rx_tick) begin
        rx_state_d = rx_in ? RX_IDLE : RX_DATA;
        rx_bit_d   = 3'd0;
      end
      RX_DATA: if (rx_tick) begin
        rx_shift_d = {rx_in, rx_shift_q[7:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_push    = rx_in;
        ferr_set   = !rx_in;
        rx_state_d = rx_in ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: if (rx_in) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
    if (div_wr) rx_cnt_d = (rx_state_q == RX_START) ? half_rl : bit_rl;
  end

  logic [7:0] rx_head;
  logic       rx_full, rx_avail;

`ifdef SCMP_UART_RXFIFO_EN
  logic rx_empty;

  scmp_uart_fifo #(.DEPTH(RX_FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .pop_i   (pop),
    .wdata_i (rx_shift_q),
    .rdata_o (rx_head),
    .empty_o (rx_empty),
    .full_o  (rx_full)
  );
  assign rx_avail = !rx_empty;
`else
  logic [7:0] hold_q;
  logic       hold_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= 8'h00;
      hold_vld_q <= 1'b0;
    end else if (rx_push && (!hold_vld_q || pop)) begin
      hold_q     <= rx_shift_q;
      hold_vld_q <= 1'b1;
    end else if (pop) begin
      hold_vld_q <= 1'b0;
    end
  end
  assign rx_head  = hold_q;
  assign rx_full  = hold_vld_q;
  assign rx_avail = hold_vld_q;
`endif

  logic ovr_q, ferr_q, irq_q;
  logic [7:0] status, rd_mux;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovr_q  <= 1'b0;
      ferr_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      ovr_q  <= (ovr_q && !stat_clr) || (rx_push && rx_full && !pop);
      ferr_q <= (ferr_q && !stat_clr) || ferr_set;
      irq_q  <= rx_avail;
    end
  end

  always_comb begin
    status                  = 8'h00;
    status[STAT_RX_AVAIL]   = rx_avail;
    status[STAT_TX_READY]   = tx_ready;
    status[STAT_RX_OVERRUN] = ovr_q;
    status[STAT_FRAME_ERR]  = ferr_q;
    case (off)
      REG_DATA:   rd_mux = rx_head;
      REG_STATUS: rd_mux = status;
      REG_DIV_LO: rd_mux = div_lo_q;
      default:    rd_mux = div_hi_q;
    endcase
  end

  assign bus.rdata = (bus.sel && !bus.rd_n) ? rd_mux : 8'h00;
  assign txd       = txd_q;
  assign irq       = irq_q;

endmodule

`default_nettype wire

// File: doc/scmp_uart.md
SCMP_UART -- requirements
Module: scmp_uart

Interface
REQ-001 Parameter BASE, default 16'hFD00, base of 4-byte register window (address bits [1:0] select register).
REQ-002 Parameter DIV_RESET, default 16'd3333, reset baud divisor (8 MHz clk / 2400 baud).
REQ-003 clk  input  1  bus-side clock, same clock that samples the memory bus (8 MHz).
REQ-004 rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 addr  input  16  full CPU address: latched high nibble concatenated with the 12-bit CPU address.
REQ-006 rd_n  input  1  CPU read strobe, active low.
REQ-007 wr_n  input  1  CPU write strobe, active low.
REQ-008 wdata  input  8  CPU write data.
REQ-009 rdata  output  8  register read data; valid while sel=1 and rd_n=0.
REQ-010 sel  output  1  combinational address hit, (addr[15:2] == BASE[15:2]); board muxes rdata into the CPU data-in path when sel=1.
REQ-011 rxd  input  1  serial in, idle high, asynchronous.
REQ-012 txd  output  1  serial out, idle high.
REQ-013 irq  output  1  high while RX data is available; intended for the CPU SA sense input.

Function
REQ-014 Registers: offset 0 DATA (R: RX byte, W: TX byte); 1 STATUS (R only); 2 DIV_LO (R/W); 3 DIV_HI (R/W).
REQ-015 STATUS bits: [0] rx_avail, [1] tx_ready, [2] rx_overrun (sticky), [3] frame_err (sticky), [7:4] read as 0.
REQ-016 A write acts once, in the first clk cycle where sel=1 and wr_n=0 after wr_n was high; a strobe held low for several cycles produces no further writes.
REQ-017 A DATA read pops the RX byte on the rising edge of rd_n while sel=1, so rdata stays stable for the whole strobe.
REQ-018 A STATUS read clears rx_overrun and frame_err on the rising edge of rd_n.
REQ-019 Baud tick: 16-bit counter reloads with {DIV_HI,DIV_LO}-1 and pulses every DIV clk cycles; DIV=0 is treated as 1.
REQ-020 A divisor write restarts the counter; any frame in progress completes at the new rate.
REQ-021 TX FSM states IDLE→START→DATA(8 bits, LSB first)→STOP→IDLE; each state lasts one full bit period.
REQ-022 TX: a DATA write in IDLE loads the shifter; tx_ready=0 from the next cycle until STOP ends.
REQ-023 TX: a DATA write while tx_ready=0 is dropped silently.
REQ-024 RX input: rxd passes through a 2-flop synchroniser.
REQ-025 RX start: a falling edge starts a half-bit timer; the line is resampled at mid-bit; high at that sample means a false start and the FSM returns to IDLE.
REQ-026 RX data: the 8 data bits are sampled at mid-bit, one bit period apart, LSB first.
REQ-027 RX stop: stop bit low sets frame_err and discards the byte; the FSM waits for rxd high before returning to IDLE.
REQ-028 RX store: a received byte with a good stop bit is stored when the stop sample is taken; if storage is full it is discarded and rx_overrun is set.
REQ-029 Store and pop in the same cycle with storage full: both take effect, and no overrun is flagged.
REQ-030 irq = rx_avail, registered.

Reset
REQ-031 rst: txd=1, tx_ready=1, rx_avail=0, irq=0, flags=0, divisor=DIV_RESET, RX storage empty, both FSMs IDLE, rdata=0.
REQ-032 rst asserted mid-frame aborts the frame immediately: txd goes to 1 the next cycle and a partial RX byte is lost.

Configuration
REQ-033 With SCMP_UART_RXFIFO_EN defined: RX storage is an 8-entry FIFO with 3-bit pointers that wrap; rx_avail=1 when not empty; full = 8 entries.
REQ-034 Without SCMP_UART_RXFIFO_EN: RX storage is a single holding register plus a valid bit; full = valid.

Structure
REQ-035 Package scmp_uart_pkg holds: the register offset constants, STATUS bit indices, the tx_state_t and rx_state_t enums, and DIV_RESET_DEFAULT.
REQ-036 One sub-module, scmp_uart_fifo (parameter DEPTH), instantiated only under SCMP_UART_RXFIFO_EN.

Verification
REQ-037 Set DIV=4, write DATA=8'hA5 → txd: low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; tx_ready=0 throughout, back to 1 after stop.
REQ-038 Drive rxd with frame 8'h3C at DIV=4 → rx_avail=1 and irq=1 after the stop sample; DATA read returns 8'h3C; rx_avail=0 after rd_n rises.
REQ-039 Receive 9 bytes 8'h01..8'h09 with no reads → FIFO build: rx_overrun=1 and reads return 01..08; non-FIFO build: rx_overrun=1 and the read returns 01.
REQ-040 RX frame with stop bit low → frame_err=1, rx_avail unchanged; STATUS read returns bit3=1, and a second STATUS read returns bit3=0.
REQ-041 Hold wr_n low for 5 cycles on DATA → exactly one TX frame; a second DATA write during the frame is ignored.
REQ-042 Assert rst during bit 3 of a TX frame → txd=1 the next cycle, tx_ready=1, and divisor reads back 3333 (DIV_LO 8'h05, DIV_HI 8'h0D).
